// File: rtl/irrigation_command_gen.sv
// rtl/irrigation_command_gen.sv - sensor conditioning and request generation for the irrigation controller
module irrigation_command_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned IRRIG_CYCLES    = 16,
    parameter int unsigned CLEAN_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sens_low_i,
    input  logic       sens_mid_i,
    input  logic       sens_high_i,
    input  logic       solo_umido_i,
    input  logic       temp_alta_i,
    input  logic [2:0] fsm_state_i,
    output logic       cheio_o,
    output logic       erro_nivel_o,
    output logic       gotejamento_o,
    output logic       aspersao_o,
    output logic       countLi_o
);

    localparam logic [7:0]  DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] IRRIG_LOAD = 16'(IRRIG_CYCLES - 1);
    localparam logic [7:0]  CLEAN_MAX  = 8'(CLEAN_CYCLES);

    localparam logic [2:0] S_FULL  = 3'b001;
    localparam logic [2:0] S_DRIP  = 3'b010;
    localparam logic [2:0] S_SPRAY = 3'b011;
    localparam logic [2:0] S_CLEAN = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE, ST_REQ_DRIP, ST_REQ_SPRAY, ST_RUN_DRIP, ST_RUN_SPRAY, ST_DONE
    } req_state_t;

    logic [2:0]       raw;
    logic [2:0]       filt_q;
    logic [2:0][7:0]  deb_cnt_q;

    req_state_t       state_q, state_d;
    logic [15:0]      irrig_cnt_q, irrig_cnt_d;
    logic             spray_q, spray_d;
    logic             drip_req_q, spray_req_q;

    logic [7:0]       clean_cnt_q, clean_cnt_d;
    logic             count_li_q;

    logic             fsm_err;
    logic [2:0]       target;

    assign raw = {sens_high_i, sens_mid_i, sens_low_i};

    // Index 0 = low, 1 = mid, 2 = high probe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q    <= '0;
            deb_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (raw[i] == filt_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_LAST) begin
                    filt_q[i]    <= raw[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign cheio_o      = filt_q[2];
    assign erro_nivel_o = (filt_q[2] & ~filt_q[1]) | (filt_q[2] & ~filt_q[0])
                        | (filt_q[1] & ~filt_q[0]);

    // Codes 101, 110 and 111 all abort any request.
    assign fsm_err = fsm_state_i[2] & (fsm_state_i[1] | fsm_state_i[0]);
    assign target  = spray_q ? S_SPRAY : S_DRIP;

    always_comb begin
        state_d     = state_q;
        irrig_cnt_d = irrig_cnt_q;
        spray_d     = spray_q;
        if (fsm_err) begin
            state_d     = ST_IDLE;
            irrig_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fsm_state_i == S_FULL && !solo_umido_i) begin
                        spray_d = temp_alta_i;
                        state_d = temp_alta_i ? ST_REQ_SPRAY : ST_REQ_DRIP;
                    end
                end
                ST_REQ_DRIP, ST_REQ_SPRAY: begin
                    if (fsm_state_i == target) begin
                        state_d     = spray_q ? ST_RUN_SPRAY : ST_RUN_DRIP;
                        irrig_cnt_d = IRRIG_LOAD;
                    end else if (fsm_state_i != S_FULL) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN_DRIP, ST_RUN_SPRAY: begin
                    if (irrig_cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        irrig_cnt_d = irrig_cnt_q - 16'd1;
                    end
                end
                ST_DONE: begin
                    if (fsm_state_i != target) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            irrig_cnt_q <= '0;
            spray_q     <= 1'b0;
            drip_req_q  <= 1'b0;
            spray_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            irrig_cnt_q <= irrig_cnt_d;
            spray_q     <= spray_d;
            drip_req_q  <= (state_d == ST_REQ_DRIP)  || (state_d == ST_RUN_DRIP);
            spray_req_q <= (state_d == ST_REQ_SPRAY) || (state_d == ST_RUN_SPRAY);
        end
    end

    assign gotejamento_o = drip_req_q;
    assign aspersao_o    = spray_req_q;

    always_comb begin
        clean_cnt_d = '0;
        if (fsm_state_i == S_CLEAN) begin
            clean_cnt_d = (clean_cnt_q == CLEAN_MAX) ? clean_cnt_q : clean_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clean_cnt_q <= '0;
            count_li_q  <= 1'b0;
        end else begin
            clean_cnt_q <= clean_cnt_d;
            count_li_q  <= (fsm_state_i == S_CLEAN) && (clean_cnt_d == CLEAN_MAX);
        end
    end

    assign countLi_o = count_li_q;

endmodule

// File: tb/tb_irrigation_command_gen.sv
// tb/tb_irrigation_command_gen.sv - directed self-checking bench for irrigation_command_gen
module tb_irrigation_command_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sens_low = 1'b0, sens_mid = 1'b0, sens_high = 1'b0;
    logic       solo_umido = 1'b1, temp_alta = 1'b0;
    logic [2:0] fsm_state = 3'b000;
    logic       cheio, erro_nivel, gotejamento, aspersao, countLi;

    int vectors = 0;
    int miscompares = 0;

    irrigation_command_gen dut (
        .clk           (clk),
        .reset         (reset),
        .sens_low_i    (sens_low),
        .sens_mid_i    (sens_mid),
        .sens_high_i   (sens_high),
        .solo_umido_i  (solo_umido),
        .temp_alta_i   (temp_alta),
        .fsm_state_i   (fsm_state),
        .cheio_o       (cheio),
        .erro_nivel_o  (erro_nivel),
        .gotejamento_o (gotejamento),
        .aspersao_o    (aspersao),
        .countLi_o     (countLi)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [4:0] expected);
        check({tag, ".cheio"},       cheio,       expected[4]);
        check({tag, ".erro_nivel"},  erro_nivel,  expected[3]);
        check({tag, ".gotejamento"}, gotejamento, expected[2]);
        check({tag, ".aspersao"},    aspersao,    expected[1]);
        check({tag, ".countLi"},     countLi,     expected[0]);
    endtask

    initial begin
        tick(2);
        check_all("reset", 5'b00000);
        reset = 1'b0;

        // Debounce with a one-cycle glitch on the high probe
        sens_low = 1'b1; sens_mid = 1'b1; sens_high = 1'b1;
        tick(3);
        check("deb_pre_glitch.cheio", cheio, 1'b0);
        sens_high = 1'b0;
        tick(1);
        check("deb_glitch.cheio", cheio, 1'b0);
        check("deb_glitch.erro", erro_nivel, 1'b0);
        sens_high = 1'b1;
        tick(3);
        check("deb_3rd.cheio", cheio, 1'b0);
        check("deb_3rd.erro", erro_nivel, 1'b0);
        tick(1);
        check("deb_4th.cheio", cheio, 1'b1);
        check("deb_4th.erro", erro_nivel, 1'b0);

        // Inconsistent probes: low drops while high stays
        sens_low = 1'b0;
        tick(3);
        check("lvl_err_3rd.erro", erro_nivel, 1'b0);
        tick(1);
        check("lvl_err_4th.erro", erro_nivel, 1'b1);
        check("lvl_err_4th.cheio", cheio, 1'b1);
        sens_low = 1'b1;
        tick(4);
        check("lvl_ok.erro", erro_nivel, 1'b0);

        // Drip request and timed run
        fsm_state = 3'b001; solo_umido = 1'b0; temp_alta = 1'b0;
        tick(1);
        check("drip_req.got", gotejamento, 1'b1);
        check("drip_req.asp", aspersao, 1'b0);
        fsm_state = 3'b010;
        tick(1);
        temp_alta = 1'b1;
        tick(15);
        check("drip_last.got", gotejamento, 1'b1);
        check("drip_last.asp", aspersao, 1'b0);
        tick(1);
        check("drip_end.got", gotejamento, 1'b0);
        tick(3);
        check("drip_done.got", gotejamento, 1'b0);
        check("drip_done.asp", aspersao, 1'b0);
        fsm_state = 3'b001;
        tick(1);
        check("done_idle.got", gotejamento, 1'b0);
        check("done_idle.asp", aspersao, 1'b0);

        // Sprinkler request, aborted by controller error
        tick(1);
        check("spray_req.asp", aspersao, 1'b1);
        check("spray_req.got", gotejamento, 1'b0);
        fsm_state = 3'b011;
        tick(4);
        check("spray_run4.asp", aspersao, 1'b1);
        fsm_state = 3'b101;
        tick(1);
        check("spray_err.asp", aspersao, 1'b0);
        check("spray_err.got", gotejamento, 1'b0);
        fsm_state = 3'b001;
        tick(1);
        check("spray_restart.asp", aspersao, 1'b1);
        fsm_state = 3'b000;
        tick(1);
        check("req_cancel.asp", aspersao, 1'b0);

        // Cleaning timer
        fsm_state = 3'b100;
        tick(7);
        check("clean_7.countLi", countLi, 1'b0);
        tick(1);
        check("clean_8.countLi", countLi, 1'b1);
        tick(2);
        check("clean_10.countLi", countLi, 1'b1);
        fsm_state = 3'b000;
        tick(1);
        check("clean_exit.countLi", countLi, 1'b0);
        fsm_state = 3'b100;
        tick(7);
        check("clean2_7.countLi", countLi, 1'b0);
        tick(1);
        check("clean2_8.countLi", countLi, 1'b1);
        fsm_state = 3'b110;
        tick(9);
        check("invalid_code.countLi", countLi, 1'b0);

        // Asynchronous reset mid-run and mid-debounce
        fsm_state = 3'b001; temp_alta = 1'b0;
        tick(1);
        check("drip2_req.got", gotejamento, 1'b1);
        fsm_state = 3'b010;
        tick(7);
        sens_high = 1'b0;
        tick(2);
        check("drip2_run.got", gotejamento, 1'b1);
        check("drip2_run.cheio", cheio, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_all("async_reset", 5'b00000);
        sens_high = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        tick(3);
        check("post_reset.got", gotejamento, 1'b0);
        check("post_reset.cheio", cheio, 1'b0);
        tick(1);
        check("post_reset_deb.cheio", cheio, 1'b1);
        check("post_reset_hold.got", gotejamento, 1'b0);
        fsm_state = 3'b001;
        tick(1);
        check("post_reset_req.got", gotejamento, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/irrigation_command_gen.md
# irrigation_command_gen

Stimulus-side companion to the irrigation state controller. It conditions the raw tank-level and field sensors into the controller's inputs: `cheio`, `erro_nivel`, `gotejamento`, `aspersao` and `countLi`. It watches the controller's 3-bit state code so it can time irrigation runs and cleaning cycles. It sits between the board sensor pins and the controller, closing the loop on the controller's `state` output.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive disagreeing samples needed before a filtered level sensor changes; range 1..255.
- `IRRIG_CYCLES`, default 16: cycles an irrigation request stays asserted once the controller is irrigating; range 1..65535.
- `CLEAN_CYCLES`, default 8: cycles the controller must spend in cleaning before `countLi` asserts; range 1..255.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `sens_low`, `sens_mid`, `sens_high`  in  1 each  raw tank level probes; 1 = water at probe.
- `solo_umido`  in  1  soil moisture adequate; 1 = no irrigation needed.
- `temp_alta`  in  1  high temperature; selects sprinkler instead of drip.
- `fsm_state`  in  3  controller state code: 000 filling, 001 full, 010 drip, 011 sprinkler, 100 cleaning, 101 error.
- `cheio`  out  1  tank full, from the filtered high probe.
- `erro_nivel`  out  1  inconsistent level-probe combination.
- `gotejamento`  out  1  drip request.
- `aspersao`  out  1  sprinkler request.
- `countLi`  out  1  cleaning time elapsed.

## Operation
- **Reset:**
  - All filtered probes are 0; debounce, irrigation and cleaning counters are 0; the request FSM is IDLE.
  - All outputs are 0.
- **Debounce**, per probe, with an 8-bit counter:
  - Each edge where raw ≠ filtered, the counter increments.
  - When the counter would reach `DEBOUNCE_CYCLES`, filtered takes raw and the counter clears.
  - Any edge where raw = filtered clears the counter.
- **Level outputs**, combinational from the filtered probes only:
  - `cheio` = filtered high.
  - `erro_nivel` = (high & !mid) | (high & !low) | (mid & !low).
- **Request FSM states:** IDLE, REQ_DRIP, REQ_SPRAY, RUN_DRIP, RUN_SPRAY, DONE.
  - IDLE → REQ_SPRAY if `fsm_state`=001 & !`solo_umido` & `temp_alta`.
  - IDLE → REQ_DRIP if `fsm_state`=001 & !`solo_umido` & !`temp_alta`.
  - REQ_x → RUN_x when `fsm_state` equals its target (010 drip, 011 sprinkler); the irrigation counter loads `IRRIG_CYCLES`-1.
  - REQ_x → IDLE if `fsm_state` ≠ 001 and ≠ target.
  - RUN_x decrements the counter each edge. At 0 it goes to DONE.
  - DONE → IDLE when `fsm_state` ≠ target.
  - Any state → IDLE on `fsm_state`=101, same edge, and the irrigation counter clears.
- **Request outputs**, registered and decoded from the next FSM state:
  - `gotejamento` = 1 in REQ_DRIP and RUN_DRIP.
  - `aspersao` = 1 in REQ_SPRAY and RUN_SPRAY.
  - The two are never both 1.
- **Cleaning timer:**
  - While `fsm_state`=100, an 8-bit counter increments each edge and saturates at `CLEAN_CYCLES`.
  - `countLi` (registered) = 1 once the counter equals `CLEAN_CYCLES`.
  - The first edge with `fsm_state` ≠ 100 clears both the counter and `countLi`.
- **Invalid `fsm_state` codes (110, 111):** treated as error (FSM → IDLE) and not as cleaning.
- `temp_alta` and `solo_umido` are sampled only on the IDLE exit edge. Later changes do not alter the request type or cancel a request.

## Timing
- **Debounce:** a raw change held for N = `DEBOUNCE_CYCLES` consecutive sampling edges updates the filtered probe at the Nth edge. `cheio` / `erro_nivel` follow in the same cycle, with no extra register.
- **Request latency:** edge k samples the IDLE exit condition; the request is high after edge k.
- **Irrigation run:** the first edge sampling the target state is edge m. The request stays high through edge m+`IRRIG_CYCLES`-1 and is low after edge m+`IRRIG_CYCLES`, so it is asserted for exactly `IRRIG_CYCLES` cycles of controller irrigation.
- **Cleaning:** the first edge sampling 100 is edge c. `countLi` goes high after edge c+`CLEAN_CYCLES`-1.
- **Reset** is asynchronous: outputs drop immediately, including mid-debounce and mid-run. Operation resumes on the first edge after release.
- **Simultaneous events:** a level error and an irrigation request may coexist; the request drops once `fsm_state` reads 101.

## Test plan
- Reset, then raise all probes together; hold `sens_high` for 3 cycles, glitch it low 1 cycle, hold 4 cycles → `cheio` rises only at the 4th edge after the glitch; `erro_nivel` stays 0.
- Filtered low=0, high=1 (probes held 4 cycles) → `erro_nivel`=1 and `cheio`=1. Restore low=1 for 4 cycles → `erro_nivel` returns to 0.
- `fsm_state`=001, `solo_umido`=0, `temp_alta`=0 → `gotejamento`=1 next cycle. Move `fsm_state` to 010 → `gotejamento` is high exactly 16 cycles, `aspersao` stays 0, then the FSM holds in DONE until `fsm_state` leaves 010.
- Same as above with `temp_alta`=1 → `aspersao`=1. Drive `fsm_state`=101 at the 5th run cycle → `aspersao`=0 after that edge; a later return to 001 with dry soil restarts the request.
- `fsm_state`=100 for 10 cycles → `countLi`=1 after the 8th edge and held. Set `fsm_state`=000 → `countLi`=0 after the next edge. A second cleaning pass needs a fresh 8 cycles.
- Assert `reset` mid-run (RUN_DRIP, counter at 7) and mid-debounce → all outputs 0 asynchronously; after release with `fsm_state`=010, no request until the FSM passes through 001 again.
